// File: rtl/afifo_arb_pkg.sv
// rtl/afifo_arb_pkg.sv - shared types and helpers for the async-FIFO write arbiter
//
// Purpose : state enum for the arbiter FSM and the channel-index width helper.
// Ports   : none (package).

package afifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Width of a channel index. Never below 1 bit so a 2-channel build still
  // has a real cur_chan bit.
  function automatic int chw_of(input int nch);
    return (nch <= 2) ? 1 : $clog2(nch);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after last_grant
//
// Purpose : choose the first requesting channel at last_grant+1, +2, ... (mod NCH).
// Ports   : req        in  NCH   request vector
//           last_grant in  IW    channel granted most recently
//           gnt_idx    out IW    winning channel (0 when gnt_vld=0)
//           gnt_vld    out 1     at least one request present

module rr_arbiter
  import afifo_arb_pkg::*;
#(
  parameter int NCH = 4,
  localparam int IW = chw_of(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  last_grant,
  output logic [IW-1:0]  gnt_idx,
  output logic           gnt_vld
);

  int cand;

  // Walk from the lowest priority (offset NCH, i.e. last_grant itself) up to
  // the highest (offset 1); later hits overwrite earlier ones, so the final
  // value is the nearest requester after last_grant.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = 0;
    for (int k = NCH; k >= 1; k--) begin
      cand = (int'(last_grant) + k) % NCH;
      if (req[cand]) begin
        gnt_idx = IW'(cand);
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/afifo_wr_arbiter.sv
// rtl/afifo_wr_arbiter.sv - packet-granular round-robin arbiter for an async FIFO write port
//
// Purpose : grants the FIFO write port to one channel for a whole packet
//           (up to MAXLEN beats), round-robin between packets.
// Macro   : AFIFO_WR_ARBITER_CHANID_EN - prefix each FIFO word with cur_chan.
// Ports   : wr_clk       in  1          write-domain clock
//           wr_rst       in  1          async active-high reset
//           in_valid     in  NCH        per-channel beat valid
//           in_data      in  NCH*WIDTH  packed payload, channel i at [i*WIDTH +: WIDTH]
//           in_last      in  NCH        per-channel end of packet
//           in_ready     out NCH        per-channel beat accepted
//           fifo_wr_data out FW         FIFO write word
//           fifo_wr_req  out 1          FIFO write strobe
//           fifo_wr_full in  1          FIFO full flag
//           busy         out 1          grant active
//           cur_chan     out CHW        granted channel (valid while busy)
//           trunc        out 1          pulse after a packet is cut at MAXLEN

module afifo_wr_arbiter
  import afifo_arb_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int WIDTH  = 8,
  parameter int MAXLEN = 256,
  localparam int CHW   = chw_of(NCH),
`ifdef AFIFO_WR_ARBITER_CHANID_EN
  localparam int FW    = WIDTH + CHW
`else
  localparam int FW    = WIDTH
`endif
) (
  input  logic                 wr_clk,
  input  logic                 wr_rst,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_last,
  output logic [NCH-1:0]       in_ready,
  output logic [FW-1:0]        fifo_wr_data,
  output logic                 fifo_wr_req,
  input  logic                 fifo_wr_full,
  output logic                 busy,
  output logic [CHW-1:0]       cur_chan,
  output logic                 trunc
);

  localparam int CW = $clog2(MAXLEN + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAXLEN - 1);

  arb_state_t       state, state_nxt;
  logic [CHW-1:0]   last_grant;
  logic [CW-1:0]    cnt;
  logic [CHW-1:0]   gnt_idx;
  logic             gnt_vld;
  logic [WIDTH-1:0] payload;
  logic             sel_valid;
  logic             sel_last;
  logic             xfer;
  logic             at_max;
  logic             done;
  logic             trunc_nxt;

  rr_arbiter #(.NCH(NCH)) u_rr (
    .req        (in_valid),
    .last_grant (last_grant),
    .gnt_idx    (gnt_idx),
    .gnt_vld    (gnt_vld)
  );

  // Select the granted channel's beat.
  always_comb begin
    payload   = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (cur_chan == CHW'(i)) begin
        payload   = in_data[i*WIDTH +: WIDTH];
        sel_valid = in_valid[i];
        sel_last  = in_last[i];
      end
    end
  end

  assign busy   = (state == BUSY);
  assign xfer   = busy & sel_valid & ~fifo_wr_full;
  assign at_max = (cnt == LAST_CNT);
  assign done   = xfer & (sel_last | at_max);
  // A packet whose real last beat lands exactly on MAXLEN is not a cut.
  assign trunc_nxt = xfer & at_max & ~sel_last;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NCH; i++) begin
      in_ready[i] = busy & ~fifo_wr_full & (cur_chan == CHW'(i));
    end
  end

  assign fifo_wr_req = xfer;

`ifdef AFIFO_WR_ARBITER_CHANID_EN
  assign fifo_wr_data = {cur_chan, payload};
`else
  assign fifo_wr_data = payload;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_vld) state_nxt = BUSY;
      BUSY:    if (done)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      state      <= IDLE;
      cur_chan   <= '0;
      last_grant <= CHW'(NCH - 1);
      cnt        <= '0;
      trunc      <= 1'b0;
    end else begin
      state <= state_nxt;
      trunc <= trunc_nxt;
      if (state == IDLE) begin
        if (gnt_vld) begin
          cur_chan <= gnt_idx;
          cnt      <= '0;
        end
      end else if (xfer) begin
        cnt <= cnt + CW'(1);
      end
      if (done) last_grant <= cur_chan;
    end
  end

endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// tb/tb_afifo_wr_arbiter.sv - scoreboard testbench for afifo_wr_arbiter

module tb_afifo_wr_arbiter;

  localparam int NCH    = 4;
  localparam int WIDTH  = 8;
  localparam int MAXLEN = 4;
  localparam int CHW    = 2;
`ifdef AFIFO_WR_ARBITER_CHANID_EN
  localparam int FW     = WIDTH + CHW;
`else
  localparam int FW     = WIDTH;
`endif

  logic                 wr_clk = 1'b0;
  logic                 wr_rst = 1'b1;
  logic [NCH-1:0]       in_valid = '0;
  logic [NCH*WIDTH-1:0] in_data = '0;
  logic [NCH-1:0]       in_last = '0;
  logic [NCH-1:0]       in_ready;
  logic [FW-1:0]        fifo_wr_data;
  logic                 fifo_wr_req;
  logic                 fifo_wr_full = 1'b0;
  logic                 busy;
  logic [CHW-1:0]       cur_chan;
  logic                 trunc;

  afifo_wr_arbiter #(.NCH(NCH), .WIDTH(WIDTH), .MAXLEN(MAXLEN)) dut (
    .wr_clk       (wr_clk),
    .wr_rst       (wr_rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .fifo_wr_data (fifo_wr_data),
    .fifo_wr_req  (fifo_wr_req),
    .fifo_wr_full (fifo_wr_full),
    .busy         (busy),
    .cur_chan     (cur_chan),
    .trunc        (trunc)
  );

  always #5 wr_clk = ~wr_clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [WIDTH:0]  src_q [NCH][$];   // {last, data} per channel
  logic [FW-1:0]   sb[$];
  int              wr_cycles[$];
  int              trunc_cycles[$];
  int              acc_cnt [NCH];

  function automatic logic [FW-1:0] exp_word(input int ch, input logic [WIDTH-1:0] d);
    logic [WIDTH+CHW-1:0] w;
    w = {CHW'(ch), d};
    return w[FW-1:0];
  endfunction

  task automatic add_pkt(input int ch, input logic [WIDTH-1:0] first, input int len);
    for (int b = 0; b < len; b++) begin
      src_q[ch].push_back({(b == len - 1), first + WIDTH'(b)});
    end
  endtask

  task automatic clear_logs();
    wr_cycles.delete();
    trunc_cycles.delete();
    for (int ch = 0; ch < NCH; ch++) acc_cnt[ch] = 0;
  endtask

  task automatic do_reset();
    @(posedge wr_clk); #1;
    wr_rst = 1'b1; in_valid = '0; in_last = '0; in_data = '0; fifo_wr_full = 1'b0;
    repeat (2) @(posedge wr_clk);
    #1 wr_rst = 1'b0;
  endtask

  // One clock: drive heads of the source queues, then at the falling edge
  // score any FIFO write and retire accepted beats.
  task automatic step(input logic full, input logic rst_now);
    logic [WIDTH:0]  beat;
    logic [FW-1:0]   exp;
    @(posedge wr_clk); #1;
    cyc++;
    for (int ch = 0; ch < NCH; ch++) begin
      if (src_q[ch].size() > 0) begin
        beat = src_q[ch][0];
        in_valid[ch] = 1'b1;
        in_data[ch*WIDTH +: WIDTH] = beat[WIDTH-1:0];
        in_last[ch] = beat[WIDTH];
      end else begin
        in_valid[ch] = 1'b0;
        in_data[ch*WIDTH +: WIDTH] = '0;
        in_last[ch] = 1'b0;
      end
    end
    fifo_wr_full = full;
    wr_rst = rst_now;
    @(negedge wr_clk);
    if (trunc) trunc_cycles.push_back(cyc);
    if (fifo_wr_req) begin
      wr_cycles.push_back(cyc);
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL fifo_write unexpected write got=%h expected=none", fifo_wr_data);
      end else begin
        exp = sb.pop_front();
        if (fifo_wr_data !== exp) begin
          failures++;
          $display("FAIL fifo_write data got=%h expected=%h", fifo_wr_data, exp);
        end
      end
    end
    for (int ch = 0; ch < NCH; ch++) begin
      if (in_valid[ch] && in_ready[ch]) begin
        void'(src_q[ch].pop_front());
        acc_cnt[ch]++;
      end
    end
  endtask

  function automatic bit drained();
    bit e;
    e = (sb.size() == 0);
    for (int ch = 0; ch < NCH; ch++) if (src_q[ch].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic run(input string name, input int budget);
    int n;
    n = 0;
    while (!drained() && n < budget) begin
      step(1'b0, 1'b0);
      n++;
    end
    step(1'b0, 1'b0);
    checks++;
    if (!drained()) begin
      failures++;
      $display("FAIL %s timeout left=%0d expected=0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0);
      checks++;
      if (busy !== 1'b0 || in_ready !== '0 || fifo_wr_req !== 1'b0 || trunc !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle busy=%b in_ready=%b req=%b trunc=%b expected=0,0000,0,0",
                 busy, in_ready, fifo_wr_req, trunc);
      end
    end
    checks++;
    if (cur_chan !== '0) begin
      failures++;
      $display("FAIL reset_cur_chan got=%0d expected=0", cur_chan);
    end
  endtask

  task automatic test_two_packets();
    clear_logs();
    add_pkt(0, 8'hA1, 3);
    add_pkt(2, 8'hC1, 3);
    for (int b = 0; b < 3; b++) sb.push_back(exp_word(0, 8'hA1 + 8'(b)));
    for (int b = 0; b < 3; b++) sb.push_back(exp_word(2, 8'hC1 + 8'(b)));
    run("two_packets", 40);
    checks++;
    if (wr_cycles.size() != 6) begin
      failures++;
      $display("FAIL two_packets writes got=%0d expected=6", wr_cycles.size());
    end else begin
      checks++;
      if (wr_cycles[2] - wr_cycles[0] != 2 || wr_cycles[5] - wr_cycles[3] != 2) begin
        failures++;
        $display("FAIL two_packets contiguous spans=%0d,%0d expected=2,2",
                 wr_cycles[2] - wr_cycles[0], wr_cycles[5] - wr_cycles[3]);
      end
      checks++;
      if (wr_cycles[3] - wr_cycles[2] != 2) begin
        failures++;
        $display("FAIL two_packets dead_cycle gap=%0d expected=2", wr_cycles[3] - wr_cycles[2]);
      end
    end
    checks++;
    if (trunc_cycles.size() != 0) begin
      failures++;
      $display("FAIL two_packets trunc got=%0d expected=0", trunc_cycles.size());
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    clear_logs();
    for (int ch = 0; ch < NCH; ch++)
      for (int i = 0; i < 100; i++)
        src_q[ch].push_back({1'b1, 2'(ch), 6'(i)});
    for (int g = 0; g < 400; g++)
      sb.push_back(exp_word(g % NCH, {2'(g % NCH), 6'(g / NCH)}));
    run("round_robin", 1000);
    for (int ch = 0; ch < NCH; ch++) begin
      checks++;
      if (acc_cnt[ch] != 100) begin
        failures++;
        $display("FAIL round_robin share ch%0d got=%0d expected=100", ch, acc_cnt[ch]);
      end
    end
    checks++;
    if (wr_cycles.size() != 400 || wr_cycles[wr_cycles.size()-1] - wr_cycles[0] != 798) begin
      failures++;
      $display("FAIL round_robin throughput writes=%0d expected=400 (2 cycles per grant)",
               wr_cycles.size());
    end
  endtask

  task automatic test_full_stall();
    int n;
    clear_logs();
    add_pkt(1, 8'h11, 3);
    for (int b = 0; b < 3; b++) sb.push_back(exp_word(1, 8'h11 + 8'(b)));
    // k=0 arbitration, k=1 first beat, k=2..6 FIFO full.
    for (int k = 0; k < 7; k++) begin
      step((k >= 2), 1'b0);
      if (k >= 2) begin
        checks++;
        if (fifo_wr_req !== 1'b0 || in_ready[1] !== 1'b0 || busy !== 1'b1) begin
          failures++;
          $display("FAIL full_stall k=%0d req=%b ready1=%b busy=%b expected=0,0,1",
                   k, fifo_wr_req, in_ready[1], busy);
        end
      end
    end
    n = 0;
    run("full_stall", 20);
    checks++;
    if (wr_cycles.size() != 3 || wr_cycles[1] - wr_cycles[0] != 6 || wr_cycles[2] - wr_cycles[1] != 1) begin
      failures++;
      $display("FAIL full_stall resume writes=%0d expected=3 with a 5-cycle hole", wr_cycles.size());
    end
  endtask

  task automatic test_truncate();
    clear_logs();
    add_pkt(3, 8'h31, 6);
    for (int b = 0; b < 6; b++) sb.push_back(exp_word(3, 8'h31 + 8'(b)));
    run("truncate", 40);
    checks++;
    if (trunc_cycles.size() != 1) begin
      failures++;
      $display("FAIL truncate pulses got=%0d expected=1", trunc_cycles.size());
    end else if (wr_cycles.size() == 6) begin
      checks++;
      if (trunc_cycles[0] != wr_cycles[3] + 1) begin
        failures++;
        $display("FAIL truncate pulse_cycle got=%0d expected=%0d", trunc_cycles[0], wr_cycles[3] + 1);
      end
    end
    checks++;
    if (wr_cycles.size() != 6 || wr_cycles[3] - wr_cycles[0] != 3 ||
        wr_cycles[4] - wr_cycles[3] != 2 || wr_cycles[5] - wr_cycles[4] != 1) begin
      failures++;
      $display("FAIL truncate split writes=%0d expected=6 as 4 then 2 after one dead cycle",
               wr_cycles.size());
    end
  endtask

  task automatic test_reset_mid_packet();
    clear_logs();
    add_pkt(1, 8'h40, 1);
    sb.push_back(exp_word(1, 8'h40));
    run("pre_reset", 20);
    add_pkt(2, 8'h51, 5);
    for (int b = 0; b < 5; b++) sb.push_back(exp_word(2, 8'h51 + 8'(b)));
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    checks++;
    if (fifo_wr_req !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid req=%b busy=%b expected=0,0", fifo_wr_req, busy);
    end
    checks++;
    if (sb.size() != 3) begin
      failures++;
      $display("FAIL reset_mid beats_written got=%0d expected=2", 5 - sb.size());
    end
    sb.delete();
    for (int ch = 0; ch < NCH; ch++) src_q[ch].delete();
    step(1'b0, 1'b0);
    add_pkt(2, 8'h21, 1);
    add_pkt(0, 8'h01, 1);
    sb.push_back(exp_word(0, 8'h01));
    sb.push_back(exp_word(2, 8'h21));
    run("post_reset_priority", 20);
  endtask

  initial begin
    for (int ch = 0; ch < NCH; ch++) acc_cnt[ch] = 0;
    test_reset();
    test_two_packets();
    test_round_robin();
    test_full_stall();
    test_truncate();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
